synch_release_gen: RTL
======================

Name: synch_release_gen

Overview:
- Generates the per-transfer release (synch) pulses that the transfer synchronisation counters consume.
- One instance sits at the completion end of each TCDM or EXT TX/RX datapath.
- Records each granted command (SID plus beat count) in an in-order queue and counts completed data beats against the head command.
- When the head command's last beat completes, emits a single-cycle synch request tagged with that command's SID.

Parameters:
- TRANS_SID_WIDTH, 1, width of transfer SID.
- MCHAN_BURST_LENGTH, 64, max bytes per command.
- BEAT_BYTES, 8, bytes per data beat.
- CMD_QUEUE_DEPTH, 4, outstanding commands tracked; power of 2, >=2.
- BEAT_CNT_WIDTH, $clog2(MCHAN_BURST_LENGTH/BEAT_BYTES)+1, derived; beat-count width.
- QCNT_WIDTH, $clog2(CMD_QUEUE_DEPTH+1), derived; occupancy width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- cmd_req_i  in  1  command issue request.
- cmd_gnt_o  out  1  command accepted; combinational, = !full.
- cmd_sid_i  in  TRANS_SID_WIDTH  SID of issued command.
- cmd_beats_i  in  BEAT_CNT_WIDTH  beats in command, 0..MCHAN_BURST_LENGTH/BEAT_BYTES.
- beat_valid_i  in  1  one data beat of head command completed this cycle.
- synch_req_o  out  1  registered single-cycle release pulse.
- synch_sid_o  out  TRANS_SID_WIDTH  SID of released command; valid with synch_req_o, else 0.
- busy_o  out  1  queue non-empty (registered state).
- outstanding_nb_o  out  QCNT_WIDTH  queued command count.
- err_o  out  1  sticky: beat_valid_i while queue empty.

Behaviour:
- Reset (rst_i=1 at clock edge): queue emptied, head beat counter=0, synch_req_o=0, synch_sid_o=0, busy_o=0, outstanding_nb_o=0, err_o=0. Queued commands are dropped with no release. cmd_gnt_o=1 after reset.
- Push: cmd_req_i && cmd_gnt_o writes {cmd_sid_i, cmd_beats_i} at the tail.
- Full: cmd_gnt_o uses pre-pop state. When full, no push even if a pop happens the same cycle.
- Head counter cnt counts beats of the head entry. On beat_valid_i && !empty:
  - cnt+1 == head.beats: pop; cnt<=0; next cycle synch_req_o=1 and synch_sid_o=head.sid.
  - otherwise: cnt<=cnt+1.
- Zero-beat head (head.beats==0): popped in the first cycle it is head, with no beat needed, and released next cycle. If beat_valid_i is also high that cycle, the beat is not consumed; it is applied to nothing and sets err_o only if the queue is then empty. Implementation may instead stall the beat one cycle; the chosen behaviour must be documented in the RTL header. Bench treats zero-beat plus coincident beat as unsupported stimulus.
- Latency: final beat at cycle N -> synch_req_o at N+1. Back-to-back single-beat commands release on consecutive cycles.
- Simultaneous push and pop: occupancy unchanged. A push into an empty queue is not visible as head until the next cycle, so a beat in the same cycle counts as an empty-queue beat.
- Empty-queue beat: ignored, err_o<=1 and held until reset.
- Occupancy: outstanding_nb_o = pushes - pops. Pointers wrap modulo CMD_QUEUE_DEPTH; full/empty use an extra pointer MSB.
- Release order is strictly command-issue order, regardless of SID.
- Synchronous reset asserted mid-transfer: any release pulse due in the following cycle is suppressed.

Decomposition:
- MCHAN_LEN_WIDTH and MCHAN_BURST_LENGTH-derived constants stay in mchan_pkg.
- Add BEAT_BYTES default constant to mchan_pkg.
- Queue entry struct {sid, beats} is local to the module, since it depends on parameters.
- One sub-module: synch_cmd_fifo, a synchronous FIFO with full/empty/count outputs and sync active-high reset. The top holds the beat counter, release register and error flag.

Test Plan:
- Single cmd sid=1, beats=4; 4 beat_valid pulses -> one synch_req_o with sid=1, 1 cycle after 4th beat; busy_o 1->0.
- Push 4 cmds (depth 4) sids 0,1,0,1, beats=1 -> cmd_gnt_o=0 on 5th request. Then 4 consecutive beats -> 4 consecutive synch pulses, sids 0,1,0,1.
- Full queue; same cycle cmd_req_i=1 and final beat of head -> pop happens, push refused, outstanding_nb_o=3; gnt=1 next cycle.
- beat_valid_i with empty queue -> err_o=1, stays 1; no synch pulse; cleared only by rst_i.
- Cmd beats=0 -> synch_req_o 2 cycles after grant with no beats; mixed with beats=8 cmd before it -> order preserved.
- 2 of 4 beats done, assert rst_i -> outputs all 0 next cycle, no release; new cmd beats=2 then releases normally.

Source files
------------

// File: rtl/mchan_pkg.sv
// Shared DMA channel constants: burst geometry and default beat size.
package mchan_pkg;

   localparam int MCHAN_BURST_LENGTH = 64;
   localparam int MCHAN_LEN_WIDTH    = $clog2(MCHAN_BURST_LENGTH) + 1;
   localparam int MCHAN_BEAT_BYTES   = 8;
   localparam int MCHAN_MAX_BEATS    = MCHAN_BURST_LENGTH / MCHAN_BEAT_BYTES;

endpackage

// File: rtl/synch_release_gen_if.sv
// Command/beat/release bundle between a datapath completion end and synch_release_gen.
// Handshake: a command is taken on a rising edge where cmd_req_i && cmd_gnt_o;
// cmd_gnt_o never depends on cmd_req_i, and beat_valid_i/synch_req_o are one-cycle strobes.
interface synch_release_gen_if #(
   parameter int TRANS_SID_WIDTH = 1,
   parameter int BEAT_CNT_WIDTH  = 4,
   parameter int QCNT_WIDTH      = 3
);

   logic                       cmd_req_i;
   logic                       cmd_gnt_o;
   logic [TRANS_SID_WIDTH-1:0] cmd_sid_i;
   logic [BEAT_CNT_WIDTH-1:0]  cmd_beats_i;
   logic                       beat_valid_i;
   logic                       synch_req_o;
   logic [TRANS_SID_WIDTH-1:0] synch_sid_o;
   logic                       busy_o;
   logic [QCNT_WIDTH-1:0]      outstanding_nb_o;
   logic                       err_o;

   modport master (
      output cmd_req_i, cmd_sid_i, cmd_beats_i, beat_valid_i,
      input  cmd_gnt_o, synch_req_o, synch_sid_o, busy_o, outstanding_nb_o, err_o
   );

   modport slave (
      input  cmd_req_i, cmd_sid_i, cmd_beats_i, beat_valid_i,
      output cmd_gnt_o, synch_req_o, synch_sid_o, busy_o, outstanding_nb_o, err_o
   );

endinterface

// File: rtl/synch_cmd_fifo.sv
// Synchronous FIFO with extra-MSB pointers; rdata_o shows the head entry combinationally.
module synch_cmd_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic             do_push, do_pop;

   always_comb begin
      full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      empty_o = (wptr_q == rptr_q);
      count_o = wptr_q - rptr_q;
      rdata_o = mem_q[rptr_q[AW-1:0]];
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
      wptr_d  = do_push ? wptr_q + PTR_ONE : wptr_q;
      rptr_d  = do_pop  ? rptr_q + PTR_ONE : rptr_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: entries are only observed between the pointers.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/synch_release_gen.sv
// Queues granted commands and emits one registered synch pulse when each head command completes.
// A zero-beat head is popped in its first head cycle; a beat arriving in that same cycle is discarded, with no error.
module synch_release_gen #(
   parameter int TRANS_SID_WIDTH    = 1,
   parameter int MCHAN_BURST_LENGTH = mchan_pkg::MCHAN_BURST_LENGTH,
   parameter int BEAT_BYTES         = mchan_pkg::MCHAN_BEAT_BYTES,
   parameter int CMD_QUEUE_DEPTH    = 4,
   parameter int BEAT_CNT_WIDTH     = $clog2(MCHAN_BURST_LENGTH / BEAT_BYTES) + 1,
   parameter int QCNT_WIDTH         = $clog2(CMD_QUEUE_DEPTH + 1)
) (
   input  logic clk_i,
   input  logic rst_i,
   synch_release_gen_if.slave io
);

   localparam int                      FIFO_CW = $clog2(CMD_QUEUE_DEPTH) + 1;
   localparam logic [BEAT_CNT_WIDTH-1:0] CNT_ONE = {{(BEAT_CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef struct packed {
      logic [TRANS_SID_WIDTH-1:0] sid;
      logic [BEAT_CNT_WIDTH-1:0]  beats;
   } cmd_t;

   cmd_t                       wr_cmd, head;
   logic                       full, empty, push, pop;
   logic [FIFO_CW-1:0]         fifo_cnt;
   logic                       zero_head, beat_in, last_beat;
   logic [BEAT_CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                       synch_req_q, synch_req_d;
   logic [TRANS_SID_WIDTH-1:0] synch_sid_q, synch_sid_d;
   logic                       err_q, err_d;

   synch_cmd_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (CMD_QUEUE_DEPTH)
   ) u_cmd_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .wdata_i (wr_cmd),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_cnt)
   );

   // Grant looks at pre-pop state, so a full queue refuses even while popping.
   always_comb begin
      push          = io.cmd_req_i && !full;
      wr_cmd.sid    = io.cmd_sid_i;
      wr_cmd.beats  = io.cmd_beats_i;
      zero_head     = !empty && (head.beats == '0);
      beat_in       = io.beat_valid_i && !empty && !zero_head;
      last_beat     = beat_in && ((cnt_q + CNT_ONE) == head.beats);
      pop           = zero_head || last_beat;
      cnt_d         = cnt_q;
      if (pop)          cnt_d = '0;
      else if (beat_in) cnt_d = cnt_q + CNT_ONE;
      err_d         = err_q || (io.beat_valid_i && empty);
      synch_req_d   = pop;
      synch_sid_d   = pop ? head.sid : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q       <= '0;
         synch_req_q <= 1'b0;
         synch_sid_q <= '0;
         err_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         synch_req_q <= synch_req_d;
         synch_sid_q <= synch_sid_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      io.cmd_gnt_o        = !full;
      io.synch_req_o      = synch_req_q;
      io.synch_sid_o      = synch_sid_q;
      io.busy_o           = !empty;
      io.outstanding_nb_o = QCNT_WIDTH'(fifo_cnt);
      io.err_o            = err_q;
   end

endmodule
